// File: rtl/hazard_unit_mc.sv
// Hazard and forwarding controller for the 5-stage RV pipeline.
// It produces EX-stage operand forwarding, load-use stalls and branch flushes.
// A two-state FSM holds EX while a multi-cycle unit (MUL/DIV) works. The unit
// can run in fixed-latency mode or in done-handshake mode.
// A saturating counter tracks how many cycles the front end was stalled.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   RegWriteM/W, RdM/W       writeback info in MEM / WB
//   RdE, Rs1E, Rs2E          EX destination and sources
//   Rs1D, Rs2D               ID sources
//   ResultSrcE               2'b01 marks a load in EX
//   Eval_branch              branch redirect resolved in EX
//   start_mc, done_mc        multi-cycle op present in EX / unit result valid
//   ForwardAE, ForwardBE     operand mux selects (10 MEM, 01 WB, 00 RF)
//   StallF/D/E, FlushD/E/M   pipeline register controls (combinational)
//   mc_busy                  FSM in BUSY (registered)
//   stall_cnt                saturating count of StallF cycles
module hazard_unit_mc #(
    parameter int unsigned AW          = 5,
    parameter int unsigned MC_MODE     = 0,
    parameter int unsigned MC_LAT      = 4,
    parameter int unsigned LOAD_USE_EN = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [AW-1:0]    RdM,
    input  logic [AW-1:0]    RdW,
    input  logic [AW-1:0]    RdE,
    input  logic [AW-1:0]    Rs1E,
    input  logic [AW-1:0]    Rs2E,
    input  logic [AW-1:0]    Rs1D,
    input  logic [AW-1:0]    Rs2D,
    input  logic [1:0]       ResultSrcE,
    input  logic             Eval_branch,
    input  logic             start_mc,
    input  logic             done_mc,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             mc_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic       MODE_DONE = (MC_MODE == 1);
    localparam logic       MC_MULTI  = (MC_LAT > 1);
    localparam logic       LU_EN     = (LOAD_USE_EN != 0);
    // The cycle that enters BUSY is already the first cycle of EX residence.
    // The completion cycle is the one with cnt==0, hence the -2.
    localparam logic [7:0] CNT_INIT  = MC_MULTI ? 8'(MC_LAT - 2) : 8'd0;

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       mc_stall;
    logic       lwstall;

    // Forward select for one operand. MEM takes priority over WB, and x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs,
                                           input logic wr_m, input logic [AW-1:0] rd_m,
                                           input logic wr_w, input logic [AW-1:0] rd_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // FSM state and latency counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic, stall decode and output priority
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mc_stall  = 1'b0;
        lwstall   = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_mc) begin
                    if (MODE_DONE) begin
                        // With done already high, the op finishes in place and does not stall.
                        if (!done_mc) begin
                            state_nxt = S_BUSY;
                            mc_stall  = 1'b1;
                        end
                    end else if (MC_MULTI) begin
                        state_nxt = S_BUSY;
                        cnt_nxt   = CNT_INIT;
                        mc_stall  = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                // In BUSY, start_mc is ignored. The completion cycle releases EX
                // and does not restart the op.
                if (MODE_DONE) begin
                    if (done_mc) begin
                        state_nxt = S_IDLE;
                    end else begin
                        mc_stall  = 1'b1;
                    end
                end else begin
                    if (cnt == 8'd0) begin
                        state_nxt = S_IDLE;
                    end else begin
                        cnt_nxt  = cnt - 8'd1;
                        mc_stall = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase

        lwstall = LU_EN && (ResultSrcE == 2'b01) && (RdE != '0) &&
                  ((Rs1D == RdE) || (Rs2D == RdE));

        if (!rst) begin
            ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
            ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
            if (mc_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (Eval_branch) begin
                // The wrong-path instruction in ID is squashed, not held.
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lwstall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign mc_busy = (state == S_BUSY);

    // Saturating front-end stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (StallF && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc.
// Four instances share the same stimulus:
//   d0: mode 0, latency 4
//   d1: mode 1
//   d2: mode 0 with a 2-bit stall counter
//   d3: load-use detection disabled
module tb_hazard_unit_mc;

    localparam int FA = 0;
    localparam int FB = 1;
    localparam int CT = 2;
    localparam int BZ = 3;
    localparam int CN = 4;
    // ctrl packing: {StallF, StallD, StallE, FlushD, FlushE, FlushM}
    localparam logic [15:0] C_NONE = 16'h00;
    localparam logic [15:0] C_LU   = 16'h32;
    localparam logic [15:0] C_BR   = 16'h06;
    localparam logic [15:0] C_MC   = 16'h39;

    logic       clk = 1'b0;
    logic       rst;
    logic       RegWriteM, RegWriteW;
    logic [4:0] RdM, RdW, RdE, Rs1E, Rs2E, Rs1D, Rs2D;
    logic [1:0] ResultSrcE;
    logic       Eval_branch, start_mc, done_mc;

    logic [1:0]  fa [4];
    logic [1:0]  fb [4];
    logic        sf [4];
    logic        sd [4];
    logic        se [4];
    logic        fd [4];
    logic        fe [4];
    logic        fm [4];
    logic        bz [4];
    logic [15:0] c0, c1, c3;
    logic [1:0]  c2;

    int vectors     = 0;
    int miscompares = 0;

    string       tag_q [$];
    int          sig_q [$];
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    hazard_unit_mc #(.AW(5), .MC_MODE(0), .MC_LAT(4), .LOAD_USE_EN(1), .CNT_W(16)) u_d0 (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .RdM(RdM), .RdW(RdW), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .ResultSrcE(ResultSrcE), .Eval_branch(Eval_branch), .start_mc(start_mc), .done_mc(done_mc),
        .ForwardAE(fa[0]), .ForwardBE(fb[0]), .StallF(sf[0]), .StallD(sd[0]), .StallE(se[0]),
        .FlushD(fd[0]), .FlushE(fe[0]), .FlushM(fm[0]), .mc_busy(bz[0]), .stall_cnt(c0));

    hazard_unit_mc #(.AW(5), .MC_MODE(1), .MC_LAT(4), .LOAD_USE_EN(1), .CNT_W(16)) u_d1 (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .RdM(RdM), .RdW(RdW), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .ResultSrcE(ResultSrcE), .Eval_branch(Eval_branch), .start_mc(start_mc), .done_mc(done_mc),
        .ForwardAE(fa[1]), .ForwardBE(fb[1]), .StallF(sf[1]), .StallD(sd[1]), .StallE(se[1]),
        .FlushD(fd[1]), .FlushE(fe[1]), .FlushM(fm[1]), .mc_busy(bz[1]), .stall_cnt(c1));

    hazard_unit_mc #(.AW(5), .MC_MODE(0), .MC_LAT(4), .LOAD_USE_EN(1), .CNT_W(2)) u_d2 (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .RdM(RdM), .RdW(RdW), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .ResultSrcE(ResultSrcE), .Eval_branch(Eval_branch), .start_mc(start_mc), .done_mc(done_mc),
        .ForwardAE(fa[2]), .ForwardBE(fb[2]), .StallF(sf[2]), .StallD(sd[2]), .StallE(se[2]),
        .FlushD(fd[2]), .FlushE(fe[2]), .FlushM(fm[2]), .mc_busy(bz[2]), .stall_cnt(c2));

    hazard_unit_mc #(.AW(5), .MC_MODE(0), .MC_LAT(4), .LOAD_USE_EN(0), .CNT_W(16)) u_d3 (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .RdM(RdM), .RdW(RdW), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .ResultSrcE(ResultSrcE), .Eval_branch(Eval_branch), .start_mc(start_mc), .done_mc(done_mc),
        .ForwardAE(fa[3]), .ForwardBE(fb[3]), .StallF(sf[3]), .StallD(sd[3]), .StallE(se[3]),
        .FlushD(fd[3]), .FlushE(fe[3]), .FlushM(fm[3]), .mc_busy(bz[3]), .stall_cnt(c3));

    function automatic logic [15:0] obs(input int s);
        int d;
        logic [15:0] v;
        d = s / 8;
        v = 16'hdead;
        case (s % 8)
            FA: v = 16'(fa[d]);
            FB: v = 16'(fb[d]);
            CT: v = 16'({sf[d], sd[d], se[d], fd[d], fe[d], fm[d]});
            BZ: v = 16'(bz[d]);
            CN: begin
                case (d)
                    0:       v = c0;
                    1:       v = c1;
                    2:       v = 16'(c2);
                    default: v = c3;
                endcase
            end
            default: v = 16'hdead;
        endcase
        return v;
    endfunction

    task automatic expect_v(input string tag, input int d, input int f, input logic [15:0] v);
        tag_q.push_back(tag);
        sig_q.push_back(d * 8 + f);
        exp_q.push_back(v);
    endtask

    task automatic check();
        string t;
        int s;
        logic [15:0] e;
        logic [15:0] o;
        #1;
        while (sig_q.size() > 0) begin
            t = tag_q.pop_front();
            s = sig_q.pop_front();
            e = exp_q.pop_front();
            o = obs(s);
            vectors++;
            assert (o === e) else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", t, o, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        RdM = '0; RdW = '0; RdE = '0; Rs1E = '0; Rs2E = '0; Rs1D = '0; Rs2D = '0;
        ResultSrcE = 2'b00; Eval_branch = 1'b0; start_mc = 1'b0; done_mc = 1'b0;
    endtask

    task automatic do_reset();
        clear();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        clear();
        rst = 1'b1;
        tick();
        tick();
        // Outputs are forced low while reset is held, even with active inputs.
        RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; start_mc = 1'b1;
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        expect_v("rst_fwdA", 0, FA, 16'd0);
        expect_v("rst_ctrl", 0, CT, C_NONE);
        expect_v("rst_busy", 0, BZ, 16'd0);
        expect_v("rst_cnt",  0, CN, 16'd0);
        check();
        tick();
        clear();
        rst = 1'b0;
        tick();

        // Forwarding priority
        RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5; Rs1E = 5'd5;
        expect_v("fwd_mem_prio", 0, FA, 16'h2);
        expect_v("fwd_ctrl_idle", 0, CT, C_NONE);
        check();
        RdM = 5'd0;
        expect_v("fwd_wb", 0, FA, 16'h1);
        check();
        Rs2E = 5'd0; RdW = 5'd0;
        expect_v("fwd_x0", 0, FB, 16'h0);
        check();
        RegWriteM = 1'b0; RdM = 5'd3; RdW = 5'd3; Rs2E = 5'd3;
        expect_v("fwd_b_wb_mem_off", 0, FB, 16'h1);
        check();
        RegWriteM = 1'b1; RdM = 5'd9; Rs2E = 5'd9;
        expect_v("fwd_b_mem", 0, FB, 16'h2);
        check();
        clear();

        // Load-use stall
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        expect_v("lu_ctrl", 0, CT, C_LU);
        expect_v("lu_cnt0", 0, CN, 16'd0);
        expect_v("lu_disabled", 3, CT, C_NONE);
        check();
        tick();
        clear();
        expect_v("lu_cnt1", 0, CN, 16'd1);
        expect_v("lu_released", 0, CT, C_NONE);
        check();
        ResultSrcE = 2'b01; RdE = 5'd0; Rs2D = 5'd0;
        expect_v("lu_rd0", 0, CT, C_NONE);
        check();
        RdE = 5'd4; Rs1D = 5'd4;
        expect_v("lu_rs1", 0, CT, C_LU);
        check();
        ResultSrcE = 2'b00;
        expect_v("lu_not_load", 0, CT, C_NONE);
        check();

        // Branch beats load-use
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; Eval_branch = 1'b1;
        expect_v("br_over_lu", 0, CT, C_BR);
        check();
        clear();
        Eval_branch = 1'b1;
        expect_v("br_alone", 0, CT, C_BR);
        check();

        // Mode 0, latency 4
        do_reset();
        start_mc = 1'b1;
        expect_v("m0_c1_ctrl", 0, CT, C_MC);
        expect_v("m0_c1_busy", 0, BZ, 16'd0);
        check();
        tick();
        Eval_branch = 1'b1;
        expect_v("m0_c2_br_masked", 0, CT, C_MC);
        expect_v("m0_c2_busy", 0, BZ, 16'd1);
        expect_v("m0_c2_cnt", 0, CN, 16'd1);
        check();
        tick();
        Eval_branch = 1'b0;
        expect_v("m0_c3_ctrl", 0, CT, C_MC);
        expect_v("m0_c3_busy", 0, BZ, 16'd1);
        check();
        tick();
        expect_v("m0_c4_release", 0, CT, C_NONE);
        expect_v("m0_c4_busy", 0, BZ, 16'd1);
        expect_v("m0_c4_cnt", 0, CN, 16'd3);
        check();
        tick();
        start_mc = 1'b0;
        expect_v("m0_done_busy", 0, BZ, 16'd0);
        expect_v("m0_done_cnt", 0, CN, 16'd3);
        expect_v("m0_done_ctrl", 0, CT, C_NONE);
        check();

        // Reset in the middle of a mode-0 op
        do_reset();
        start_mc = 1'b1;
        tick();
        expect_v("rm_c2_busy", 0, BZ, 16'd1);
        check();
        rst = 1'b1;
        RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
        expect_v("rm_ctrl", 0, CT, C_NONE);
        expect_v("rm_busy", 0, BZ, 16'd0);
        expect_v("rm_cnt", 0, CN, 16'd0);
        expect_v("rm_fwd", 0, FA, 16'd0);
        check();
        tick();
        clear();
        rst = 1'b0;
        tick();
        start_mc = 1'b1;
        expect_v("rr_c1_ctrl", 0, CT, C_MC);
        check();
        tick();
        expect_v("rr_c2_ctrl", 0, CT, C_MC);
        expect_v("rr_c2_busy", 0, BZ, 16'd1);
        check();
        tick();
        expect_v("rr_c3_ctrl", 0, CT, C_MC);
        check();
        tick();
        expect_v("rr_c4_ctrl", 0, CT, C_NONE);
        expect_v("rr_c4_busy", 0, BZ, 16'd1);
        check();
        tick();
        start_mc = 1'b0;
        expect_v("rr_cnt", 0, CN, 16'd3);
        expect_v("rr_idle", 0, BZ, 16'd0);
        check();

        // Mode 1: done arrives six cycles after start
        do_reset();
        start_mc = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            expect_v("m1_stall", 1, CT, C_MC);
            expect_v("m1_busy", 1, BZ, (k == 1) ? 16'd0 : 16'd1);
            check();
            tick();
        end
        done_mc = 1'b1;
        expect_v("m1_done_release", 1, CT, C_NONE);
        expect_v("m1_done_busy", 1, BZ, 16'd1);
        check();
        tick();
        start_mc = 1'b0; done_mc = 1'b0;
        expect_v("m1_after_busy", 1, BZ, 16'd0);
        expect_v("m1_cnt", 1, CN, 16'd6);
        check();
        // Start and done in the same cycle
        start_mc = 1'b1; done_mc = 1'b1;
        expect_v("m1_same_ctrl", 1, CT, C_NONE);
        check();
        tick();
        start_mc = 1'b0; done_mc = 1'b0;
        expect_v("m1_same_busy", 1, BZ, 16'd0);
        expect_v("m1_same_cnt", 1, CN, 16'd6);
        check();

        // Counter saturation on a 2-bit counter
        do_reset();
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        tick();
        tick();
        expect_v("sat_cnt2", 2, CN, 16'd2);
        check();
        tick();
        tick();
        tick();
        clear();
        expect_v("sat_cnt_hold", 2, CN, 16'd3);
        expect_v("sat_wide_cnt", 0, CN, 16'd5);
        check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
